// File: rtl/cdc_edge_event.sv
// cdc_edge_event: glitch-filtered edge detector behind a 2-flop synchronizer.
// Emits rise/fall pulses, an edge counter and a one-deep event register.
module cdc_edge_event #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             evt_valid,
    output logic             evt_type,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    input  logic             clr_ovf
);

    typedef enum logic [1:0] {
        LOW,
        QUAL_HIGH,
        HIGH,
        QUAL_LOW
    } state_t;

    localparam logic [4:0] SC = 5'(STABLE_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         qcnt_q, qcnt_d;
    logic [4:0]         qnext;
    logic               qdone;
    logic               acc_rise, acc_fall;

    logic               level_q, level_d;
    logic               rise_q, fall_q;
    logic               valid_q, valid_d;
    logic               type_q, type_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    assign qnext = {1'b0, qcnt_q} + 5'd1;
    assign qdone = (qnext == SC);

    // Stability filter: a new level must be seen STABLE_CYCLES times in a row.
    always_comb begin
        state_d  = state_q;
        qcnt_d   = qcnt_q;
        acc_rise = 1'b0;
        acc_fall = 1'b0;
        unique case (state_q)
            LOW: begin
                if (sync_in) begin
                    if (SC == 5'd1) begin
                        state_d  = HIGH;
                        qcnt_d   = 4'd0;
                        acc_rise = 1'b1;
                    end else begin
                        state_d = QUAL_HIGH;
                        qcnt_d  = 4'd1;
                    end
                end
            end
            QUAL_HIGH: begin
                if (!sync_in) begin
                    state_d = LOW;
                    qcnt_d  = 4'd0;
                end else if (qdone) begin
                    state_d  = HIGH;
                    qcnt_d   = 4'd0;
                    acc_rise = 1'b1;
                end else begin
                    qcnt_d = qnext[3:0];
                end
            end
            HIGH: begin
                if (!sync_in) begin
                    if (SC == 5'd1) begin
                        state_d  = LOW;
                        qcnt_d   = 4'd0;
                        acc_fall = 1'b1;
                    end else begin
                        state_d = QUAL_LOW;
                        qcnt_d  = 4'd1;
                    end
                end
            end
            QUAL_LOW: begin
                if (sync_in) begin
                    state_d = HIGH;
                    qcnt_d  = 4'd0;
                end else if (qdone) begin
                    state_d  = LOW;
                    qcnt_d   = 4'd0;
                    acc_fall = 1'b1;
                end else begin
                    qcnt_d = qnext[3:0];
                end
            end
        endcase
    end

    // Event side: level, counter, one-deep event slot and sticky overflow.
    always_comb begin
        level_d = level_q;
        valid_d = valid_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (acc_rise || acc_fall) begin
            level_d = acc_rise;
            cnt_d   = cnt_q + 1'b1;
            if (!valid_q || evt_ready) begin
                valid_d = 1'b1;
                type_d  = acc_rise;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end
    end

    // All state and outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOW;
            qcnt_q  <= 4'd0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            valid_q <= 1'b0;
            type_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            level_q <= level_d;
            rise_q  <= acc_rise;
            fall_q  <= acc_fall;
            valid_q <= valid_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign evt_valid  = valid_q;
    assign evt_type   = type_q;
    assign evt_count  = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cdc_edge_event.sv
// tb_cdc_edge_event: two DUT configurations driven by shared stimulus,
// checked against a run-length reference model.
module tb_cdc_edge_event;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_in = 1'b0;
    logic evt_ready = 1'b0;
    logic clr_ovf = 1'b0;

    logic       d0_level, d0_rise, d0_fall, d0_valid, d0_type, d0_ovf;
    logic [7:0] d0_cnt;
    logic       d1_level, d1_rise, d1_fall, d1_valid, d1_type, d1_ovf;
    logic [1:0] d1_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int SCv [2] = '{2, 1};
    localparam int Wv  [2] = '{8, 2};

    int m_lvl [2];
    int m_run [2];
    int m_rp  [2];
    int m_fp  [2];
    int m_v   [2];
    int m_t   [2];
    int m_cnt [2];
    int m_ovf [2];

    always #5 clk = ~clk;

    cdc_edge_event #(.STABLE_CYCLES(2), .CNT_W(8)) u0 (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .level      (d0_level),
        .rise_pulse (d0_rise),
        .fall_pulse (d0_fall),
        .evt_valid  (d0_valid),
        .evt_type   (d0_type),
        .evt_ready  (evt_ready),
        .evt_count  (d0_cnt),
        .overflow   (d0_ovf),
        .clr_ovf    (clr_ovf)
    );

    cdc_edge_event #(.STABLE_CYCLES(1), .CNT_W(2)) u1 (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .level      (d1_level),
        .rise_pulse (d1_rise),
        .fall_pulse (d1_fall),
        .evt_valid  (d1_valid),
        .evt_type   (d1_type),
        .evt_ready  (evt_ready),
        .evt_count  (d1_cnt),
        .overflow   (d1_ovf),
        .clr_ovf    (clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: accept when the new level has been sampled SC times in a row.
    task automatic model_step(input int i);
        int acc;
        int s;
        int ovset;
        s = int'(sync_in);
        if (rst) begin
            m_lvl[i] = 0; m_run[i] = 0; m_rp[i] = 0; m_fp[i] = 0;
            m_v[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            return;
        end
        acc = 0;
        ovset = 0;
        if (s != m_lvl[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == SCv[i]) begin
            acc = 1;
            m_lvl[i] = s;
            m_run[i] = 0;
        end
        m_rp[i] = acc & s;
        m_fp[i] = acc & (1 - s);
        if (acc != 0) begin
            m_cnt[i] = (m_cnt[i] + 1) % (1 << Wv[i]);
            if (m_v[i] == 0 || evt_ready) begin
                m_v[i] = 1;
                m_t[i] = s;
            end else begin
                ovset = 1;
            end
        end else if (m_v[i] != 0 && evt_ready) begin
            m_v[i] = 0;
        end
        if (ovset != 0) m_ovf[i] = 1;
        else if (clr_ovf) m_ovf[i] = 0;
    endtask

    task automatic check_all();
        chk("d0_level", 32'(d0_level), 32'(m_lvl[0]));
        chk("d0_rise",  32'(d0_rise),  32'(m_rp[0]));
        chk("d0_fall",  32'(d0_fall),  32'(m_fp[0]));
        chk("d0_valid", 32'(d0_valid), 32'(m_v[0]));
        if (m_v[0] != 0) chk("d0_type", 32'(d0_type), 32'(m_t[0]));
        chk("d0_cnt",   32'(d0_cnt),   32'(m_cnt[0]));
        chk("d0_ovf",   32'(d0_ovf),   32'(m_ovf[0]));
        chk("d1_level", 32'(d1_level), 32'(m_lvl[1]));
        chk("d1_rise",  32'(d1_rise),  32'(m_rp[1]));
        chk("d1_fall",  32'(d1_fall),  32'(m_fp[1]));
        chk("d1_valid", 32'(d1_valid), 32'(m_v[1]));
        if (m_v[1] != 0) chk("d1_type", 32'(d1_type), 32'(m_t[1]));
        chk("d1_cnt",   32'(d1_cnt),   32'(m_cnt[1]));
        chk("d1_ovf",   32'(d1_ovf),   32'(m_ovf[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic drive(input logic s, input logic rdy, input logic clr,
                         input int n);
        sync_in   = s;
        evt_ready = rdy;
        clr_ovf   = clr;
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        // Reset with input low.
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2);

        // First rise, consumer idle.
        sync_in = 1'b1;
        cyc();
        chk("t1_no_rise_yet", 32'(d0_rise), 32'd0);
        cyc();
        chk("t1_rise", 32'(d0_rise), 32'd1);
        chk("t1_level", 32'(d0_level), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 3);
        chk("t1_valid", 32'(d0_valid), 32'd1);
        chk("t1_type", 32'(d0_type), 32'd1);
        chk("t1_cnt", 32'(d0_cnt), 32'd1);

        // Consume, fall back, then a one-cycle glitch.
        drive(1'b1, 1'b1, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 4);
        drive(1'b1, 1'b1, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 4);
        chk("glitch_level", 32'(d0_level), 32'd0);
        chk("glitch_cnt", 32'(d0_cnt), 32'd2);

        // Alternating 3-cycle levels with ready held high.
        for (int e = 0; e < 6; e++) begin
            drive(((e % 2) == 0), 1'b1, 1'b0, 3);
        end
        chk("alt_cnt", 32'(d0_cnt), 32'd8);
        chk("alt_ovf", 32'(d0_ovf), 32'd0);

        // Settle low, consume, then rise+fall with consumer stalled.
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b1, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0, 3);
        chk("ovf_type", 32'(d0_type), 32'd1);
        chk("ovf_set", 32'(d0_ovf), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1);
        chk("ovf_clr", 32'(d0_ovf), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 2);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) sync_in = ~sync_in;
            evt_ready = ($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            cyc();
        end

        // Reset asserted in the middle of qualifying a rise.
        drive(1'b0, 1'b1, 1'b0, 4);
        drive(1'b1, 1'b0, 1'b0, 1);
        rst = 1'b1;
        #1;
        chk("async_d1_cnt", 32'(d1_cnt), 32'd0);
        chk("async_d1_level", 32'(d1_level), 32'd0);
        chk("async_d0_valid", 32'(d0_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2);
        rst = 1'b0;
        cyc();
        chk("rq_no_rise", 32'(d0_rise), 32'd0);
        cyc();
        chk("rq_rise", 32'(d0_rise), 32'd1);
        chk("rq_cnt", 32'(d0_cnt), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
